// File: rtl/pitch_axil_pkg.sv
// Shared constants and state types for the pitch AXI4-Lite register block.
package pitch_axil_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

endpackage

// File: rtl/pitch_axil_wreg.sv
// One byte-strobed 32-bit register with a one-cycle "written" pulse.
module pitch_axil_wreg
    import pitch_axil_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q,
    output logic              pulse
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            pulse <= 1'b0;
        end else begin
            // An all-zero strobe is a legal no-op write and must not pulse.
            pulse <= wr_en && (|wstrb);
            for (int b = 0; b < STRB_W; b++) begin
                if (wr_en && wstrb[b]) begin
                    q[b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/pitch_axil_regs.sv
// AXI4-Lite slave exposing C_NUM_REGS read/write registers to user logic.
// Define PITCH_AXIL_SLVERR_EN to answer unmapped accesses with SLVERR.
module pitch_axil_regs
    import pitch_axil_pkg::*;
#(
    parameter int C_ADDR_W   = 5,
    parameter int C_NUM_REGS = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [C_ADDR_W-1:0]          s_axi_awaddr,
    input  logic [2:0]                   s_axi_awprot,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [DATA_W-1:0]            s_axi_wdata,
    input  logic [STRB_W-1:0]            s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [C_ADDR_W-1:0]          s_axi_araddr,
    input  logic [2:0]                   s_axi_arprot,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [DATA_W-1:0]            s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [DATA_W*C_NUM_REGS-1:0] reg_o,
    output logic [C_NUM_REGS-1:0]        wr_pulse_o
);

    localparam int IDX_W = C_ADDR_W - 2;

`ifdef PITCH_AXIL_SLVERR_EN
    localparam logic [1:0] UNMAPPED_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] UNMAPPED_RESP = RESP_OKAY;
`endif

    w_state_t w_state, w_state_nx;
    r_state_t r_state, r_state_nx;

    logic              aw_held, w_held, do_write, rd_hs;
    logic [IDX_W-1:0]  aw_idx_q, wr_idx, rd_idx;
    logic [DATA_W-1:0] wdata_q, wr_data, rd_word;
    logic [STRB_W-1:0] wstrb_q, wr_strb;
    logic [DATA_W-1:0] reg_q [C_NUM_REGS];
    logic [C_NUM_REGS-1:0] wr_en;

    function automatic logic is_mapped(input logic [IDX_W-1:0] idx);
        return 32'(idx) < C_NUM_REGS;
    endfunction

    // A captured half of the write takes precedence over the live bus.
    assign wr_idx  = aw_held ? aw_idx_q : s_axi_awaddr[C_ADDR_W-1:2];
    assign wr_data = w_held  ? wdata_q  : s_axi_wdata;
    assign wr_strb = w_held  ? wstrb_q  : s_axi_wstrb;
    assign rd_idx  = s_axi_araddr[C_ADDR_W-1:2];

    always_ff @(posedge ACLK) begin
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx    = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        do_write      = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                s_axi_awready = !aw_held && !ARESET;
                s_axi_wready  = !w_held && !ARESET;
                if (!ARESET && (aw_held || s_axi_awvalid) && (w_held || s_axi_wvalid)) begin
                    do_write   = 1'b1;
                    w_state_nx = W_RESP;
                end
            end
            W_RESP: if (s_axi_bready) w_state_nx = W_IDLE;
            default: w_state_nx = W_IDLE;
        endcase
    end

    assign s_axi_bvalid = (w_state == W_RESP);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            aw_idx_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            s_axi_bresp <= RESP_OKAY;
        end else if (do_write) begin
            aw_held     <= 1'b0;
            w_held      <= 1'b0;
            s_axi_bresp <= is_mapped(wr_idx) ? RESP_OKAY : UNMAPPED_RESP;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held  <= 1'b1;
                aw_idx_q <= s_axi_awaddr[C_ADDR_W-1:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held  <= 1'b1;
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < C_NUM_REGS; k++) begin : g_reg
            assign wr_en[k] = do_write && (32'(wr_idx) == k);
            pitch_axil_wreg u_wreg (
                .clk   (ACLK),
                .rst   (ARESET),
                .wr_en (wr_en[k]),
                .wstrb (wr_strb),
                .wdata (wr_data),
                .q     (reg_q[k]),
                .pulse (wr_pulse_o[k])
            );
            assign reg_o[DATA_W*k +: DATA_W] = reg_q[k];
        end
    endgenerate

    always_ff @(posedge ACLK) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_state_nx;
    end

    always_comb begin
        r_state_nx    = r_state;
        s_axi_arready = 1'b0;
        rd_hs         = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                s_axi_arready = !ARESET;
                rd_hs         = !ARESET && s_axi_arvalid;
                if (rd_hs) r_state_nx = R_DATA;
            end
            R_DATA: if (s_axi_rready) r_state_nx = R_IDLE;
            default: r_state_nx = R_IDLE;
        endcase
    end

    assign s_axi_rvalid = (r_state == R_DATA);

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (32'(rd_idx) == 32'(i)) rd_word = reg_q[i];
        end
    end

    // Sampling the pre-edge register value gives read-before-write on collisions.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else if (rd_hs) begin
            s_axi_rdata <= is_mapped(rd_idx) ? rd_word : '0;
            s_axi_rresp <= is_mapped(rd_idx) ? RESP_OKAY : UNMAPPED_RESP;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_pitch_axil_regs.sv
// Scoreboard bench for pitch_axil_regs: directed scenarios plus randomized traffic.
module tb_pitch_axil_regs;

    localparam int NREG = 4;
    localparam logic [1:0] OKAY = 2'b00;
`ifdef PITCH_AXIL_SLVERR_EN
    localparam logic [1:0] UNM_RESP = 2'b10;
`else
    localparam logic [1:0] UNM_RESP = 2'b00;
`endif

    logic ACLK = 1'b0;
    logic ARESET;
    logic [4:0] s_axi_awaddr, s_axi_araddr;
    logic [2:0] s_axi_awprot, s_axi_arprot;
    logic s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata, s_axi_rdata;
    logic [3:0] s_axi_wstrb;
    logic [1:0] s_axi_bresp, s_axi_rresp;
    logic s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic s_axi_rvalid, s_axi_rready;
    logic [32*NREG-1:0] reg_o;
    logic [NREG-1:0] wr_pulse_o;

    always #5 ACLK = ~ACLK;

    pitch_axil_regs #(.C_ADDR_W(5), .C_NUM_REGS(NREG)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .reg_o(reg_o), .wr_pulse_o(wr_pulse_o)
    );

    int checks = 0;
    int errors = 0;
    bit bp_en = 1'b0;
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    logic [31:0] model[NREG];
    int exp_pulse[NREG];
    int obs_pulse[NREG];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected, expected response", name);
    endtask

    // Monitor: pops the scoreboard whenever a handshake is about to complete.
    always @(negedge ACLK) begin
        if (ARESET === 1'b0) begin
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b.size() == 0) fail_now("b_unexpected");
                else check("bresp", 32'(s_axi_bresp), 32'(exp_b.pop_front()));
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r.size() == 0) fail_now("r_unexpected");
                else begin
                    logic [33:0] e;
                    e = exp_r.pop_front();
                    check("rdata", s_axi_rdata, e[31:0]);
                    check("rresp", 32'(s_axi_rresp), 32'(e[33:32]));
                end
            end
            for (int k = 0; k < NREG; k++) if (wr_pulse_o[k]) obs_pulse[k]++;
        end
    end

    initial begin
        forever begin
            @(posedge ACLK);
            #1;
            if (bp_en) begin
                s_axi_bready = ($urandom_range(0, 3) != 0);
                s_axi_rready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly);
        int idx, cyc;
        bit aw_on, w_on, aw_done, w_done, aw_hs, w_hs, chk_aw, chk_w;
        idx = int'(addr[4:2]);
        cyc = 0; aw_on = 0; w_on = 0; aw_done = 0; w_done = 0; chk_aw = 0; chk_w = 0;
        if (idx < NREG) begin
            exp_b.push_back(OKAY);
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
            if (strb != 4'b0) exp_pulse[idx]++;
        end else begin
            exp_b.push_back(UNM_RESP);
        end
        @(posedge ACLK);
        #1;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        if (aw_dly == 0) begin s_axi_awvalid = 1'b1; aw_on = 1; end
        if (w_dly == 0)  begin s_axi_wvalid = 1'b1;  w_on = 1;  end
        while (!(aw_done && w_done)) begin
            @(negedge ACLK);
            if (chk_aw) check("awready_after_capture", 32'(s_axi_awready), 0);
            if (chk_w)  check("wready_after_capture", 32'(s_axi_wready), 0);
            chk_aw = 0; chk_w = 0;
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            @(posedge ACLK);
            #1;
            cyc++;
            if (aw_hs) begin s_axi_awvalid = 1'b0; chk_aw = !(w_hs || w_done); end
            if (w_hs)  begin s_axi_wvalid = 1'b0;  chk_w = !(aw_hs || aw_done); end
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
            if (!aw_on && cyc >= aw_dly) begin s_axi_awvalid = 1'b1; aw_on = 1; end
            if (!w_on && cyc >= w_dly)   begin s_axi_wvalid = 1'b1;  w_on = 1;  end
            if (cyc > 300) begin
                fail_now("write_timeout");
                s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
                break;
            end
        end
        if (aw_done && w_done) begin
            @(negedge ACLK);
            check("bvalid_after_write", 32'(s_axi_bvalid), 1);
            if (idx < NREG) check("reg_o_after_write", reg_o[idx*32 +: 32], model[idx]);
        end
    endtask

    task automatic do_read(input logic [4:0] addr, input bit push);
        int idx, cyc;
        bit hs;
        idx = int'(addr[4:2]);
        cyc = 0;
        if (push) begin
            if (idx < NREG) exp_r.push_back({OKAY, model[idx]});
            else            exp_r.push_back({UNM_RESP, 32'h0});
        end
        @(posedge ACLK);
        #1;
        s_axi_araddr = addr;
        s_axi_arvalid = 1'b1;
        while (s_axi_arvalid) begin
            @(negedge ACLK);
            hs = s_axi_arvalid && s_axi_arready;
            @(posedge ACLK);
            #1;
            cyc++;
            if (hs) s_axi_arvalid = 1'b0;
            if (cyc > 300) begin
                fail_now("read_timeout");
                s_axi_arvalid = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((s_axi_bvalid || s_axi_rvalid || exp_b.size() != 0 || exp_r.size() != 0) && n < 300) begin
            @(negedge ACLK);
            n++;
        end
        if (n >= 300) fail_now("drain_timeout");
    endtask

    initial begin
        ARESET = 1'b1;
        s_axi_awaddr = '0; s_axi_araddr = '0; s_axi_awprot = 3'b0; s_axi_arprot = 3'b0;
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_bready = 1; s_axi_rready = 1;
        for (int k = 0; k < NREG; k++) begin model[k] = '0; exp_pulse[k] = 0; obs_pulse[k] = 0; end

        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        check("rst_awready", 32'(s_axi_awready), 0);
        check("rst_wready", 32'(s_axi_wready), 0);
        check("rst_arready", 32'(s_axi_arready), 0);
        check("rst_bvalid", 32'(s_axi_bvalid), 0);
        check("rst_rvalid", 32'(s_axi_rvalid), 0);
        check("rst_reg_o", 32'(|reg_o), 0);
        check("rst_wr_pulse", 32'(wr_pulse_o), 0);
        check("rst_rdata", s_axi_rdata, 0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        check("post_rst_awready", 32'(s_axi_awready), 1);
        check("post_rst_wready", 32'(s_axi_wready), 1);
        check("post_rst_arready", 32'(s_axi_arready), 1);

        // Basic write/readback of every register.
        for (int k = 0; k < NREG; k++) do_write(5'(k * 4), 32'(k + 1), 4'hF, 0, 0);
        for (int k = 0; k < NREG; k++) do_read(5'(k * 4), 1);
        wait_idle();

        // AW leads W by 3 cycles.
        do_write(5'h08, 32'hDEADBEEF, 4'hF, 0, 3);
        check("word2_deadbeef", reg_o[95:64], 32'hDEADBEEF);
        // W leads AW by 2 cycles.
        do_write(5'h0C, 32'h12345678, 4'hF, 2, 0);

        // Byte strobes.
        do_write(5'h04, 32'hAABBCCDD, 4'hF, 0, 0);
        do_write(5'h04, 32'h11223344, 4'b0101, 0, 0);
        do_read(5'h04, 1);
        wait_idle();
        check("word1_strobed", reg_o[63:32], 32'hAA22CC44);

        // Zero strobe, unmapped write and reads (low address bits ignored).
        do_write(5'h00, 32'hFFFFFFFF, 4'h0, 0, 0);
        do_write(5'h14, 32'hCAFEF00D, 4'hF, 0, 0);
        do_read(5'h10, 1);
        do_read(5'h1F, 1);
        do_read(5'h03, 1);
        wait_idle();

        // Response backpressure blocks the next write.
        s_axi_bready = 1'b0;
        do_write(5'h04, 32'h0BADF00D, 4'hF, 0, 0);
        fork
            do_write(5'h08, 32'h600DCAFE, 4'hF, 0, 0);
            begin
                repeat (5) begin
                    @(negedge ACLK);
                    check("bp_bvalid", 32'(s_axi_bvalid), 1);
                    check("bp_awready", 32'(s_axi_awready), 0);
                    check("bp_wready", 32'(s_axi_wready), 0);
                end
                @(posedge ACLK);
                #1;
                s_axi_bready = 1'b1;
            end
        join
        wait_idle();

        // Same-cycle read and write of one register returns the old value.
        exp_r.push_back({OKAY, model[2]});
        fork
            do_read(5'h08, 0);
            do_write(5'h08, 32'h5555AAAA, 4'hF, 0, 0);
        join
        wait_idle();

        // Randomized traffic with random B/R backpressure.
        bp_en = 1'b1;
        repeat (80) begin
            if ($urandom_range(0, 1) == 1)
                do_write(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else
                do_read(5'($urandom_range(0, 31)), 1);
        end
        bp_en = 1'b0;
        @(posedge ACLK);
        #1;
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        wait_idle();

        // Reset in the middle of outstanding B and R responses.
        s_axi_bready = 1'b0;
        s_axi_rready = 1'b0;
        fork
            do_write(5'h00, 32'h5A5A5A5A, 4'hF, 0, 0);
            do_read(5'h04, 1);
        join
        begin
            int n;
            n = 0;
            while (!(s_axi_bvalid && s_axi_rvalid) && n < 50) begin @(negedge ACLK); n++; end
            if (n >= 50) fail_now("valids_before_reset");
        end
        @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        exp_b.delete();
        exp_r.delete();
        for (int k = 0; k < NREG; k++) model[k] = '0;
        @(posedge ACLK);
        #1;
        @(negedge ACLK);
        check("mid_rst_bvalid", 32'(s_axi_bvalid), 0);
        check("mid_rst_rvalid", 32'(s_axi_rvalid), 0);
        check("mid_rst_reg_o", 32'(|reg_o), 0);
        check("mid_rst_awready", 32'(s_axi_awready), 0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_rready = 1'b1;
        @(negedge ACLK);
        check("after_rst_arready", 32'(s_axi_arready), 1);
        check("after_rst_awready", 32'(s_axi_awready), 1);
        do_read(5'h00, 1);
        wait_idle();

        for (int k = 0; k < NREG; k++) check($sformatf("wr_pulse_count_%0d", k), 32'(obs_pulse[k]), 32'(exp_pulse[k]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
